// File: rtl/wb_port_arbiter_if.sv
// Bundle between the register-file write-port arbiter and its clients: W-stage
// writeback, long-latency unit result port, hazard-unit query and status.
interface wb_port_arbiter_if #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2
);
  logic                     pipe_we_i;
  logic [4:0]               pipe_rd_i;
  logic [XLEN-1:0]          pipe_data_i;
  logic                     lu_valid_i;
  logic [4:0]               lu_rd_i;
  logic [XLEN-1:0]          lu_data_i;
  logic                     lu_ready_o;
  logic                     rf_we_o;
  logic [4:0]               rf_addr_o;
  logic [XLEN-1:0]          rf_data_o;
  logic                     stall_o;
  logic [4:0]               chk_rs1_i;
  logic [4:0]               chk_rs2_i;
  logic                     pend_hit_o;
  logic [$clog2(DEPTH):0]   fifo_count_o;

  modport slave (
    input  pipe_we_i, pipe_rd_i, pipe_data_i,
    input  lu_valid_i, lu_rd_i, lu_data_i,
    input  chk_rs1_i, chk_rs2_i,
    output lu_ready_o, rf_we_o, rf_addr_o, rf_data_o,
    output stall_o, pend_hit_o, fifo_count_o
  );

  modport master (
    output pipe_we_i, pipe_rd_i, pipe_data_i,
    output lu_valid_i, lu_rd_i, lu_data_i,
    output chk_rs1_i, chk_rs2_i,
    input  lu_ready_o, rf_we_o, rf_addr_o, rf_data_o,
    input  stall_o, pend_hit_o, fifo_count_o
  );
endinterface

// File: rtl/wb_port_arbiter.sv
// Shares the register-file write port between W-stage writeback (always wins)
// and a long-latency unit whose results wait in a small FIFO for idle cycles.
module wb_port_arbiter #(
  parameter int XLEN         = 32,
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  wb_port_arbiter_if.slave  bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int AGE_W = $clog2(STARVE_LIMIT + 1);

  logic [4:0]      r_rd_mem   [DEPTH];
  logic [XLEN-1:0] r_data_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr, r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic [AGE_W-1:0] r_age;

  logic             w_empty, w_full, w_pipe_claim;
  logic             w_deq, w_bypass, w_lu_ready, w_enq;
  logic [CNT_W-1:0] w_count_next;
  logic [AGE_W-1:0] w_age_next;
  logic [DEPTH-1:0] w_slot_vld;
  logic             w_pend_hit;

  assign w_empty      = (r_count == '0);
  assign w_full       = (r_count == CNT_W'(DEPTH));
  assign w_pipe_claim = bus.pipe_we_i && (bus.pipe_rd_i != 5'd0);
  assign w_deq        = !rst && !w_pipe_claim && !w_empty;
  assign w_bypass     = !rst && !w_pipe_claim && w_empty &&
                        bus.lu_valid_i && (bus.lu_rd_i != 5'd0);
  assign w_lu_ready   = !rst && (!w_full || w_deq);
  // rd=0 results complete the handshake but are never stored.
  assign w_enq        = bus.lu_valid_i && w_lu_ready &&
                        (bus.lu_rd_i != 5'd0) && !w_bypass;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    w_count_next = r_count;
    case ({w_enq, w_deq})
      2'b10:   w_count_next = r_count + CNT_W'(1);
      2'b01:   w_count_next = r_count - CNT_W'(1);
      default: w_count_next = r_count;
    endcase
  end

  // Age only counts cycles in which an existing head was passed over.
  always_comb begin
    w_age_next = r_age;
    if (w_deq || w_empty)
      w_age_next = '0;
    else if (r_age != AGE_W'(STARVE_LIMIT))
      w_age_next = r_age + AGE_W'(1);
  end

  always_comb begin
    bus.rf_we_o   = 1'b0;
    bus.rf_addr_o = 5'd0;
    bus.rf_data_o = '0;
    if (rst) begin
      bus.rf_we_o = 1'b0;
    end else if (w_pipe_claim) begin
      bus.rf_we_o   = 1'b1;
      bus.rf_addr_o = bus.pipe_rd_i;
      bus.rf_data_o = bus.pipe_data_i;
    end else if (!w_empty) begin
      bus.rf_we_o   = 1'b1;
      bus.rf_addr_o = r_rd_mem[r_rd_ptr];
      bus.rf_data_o = r_data_mem[r_rd_ptr];
    end else if (w_bypass) begin
      bus.rf_we_o   = 1'b1;
      bus.rf_addr_o = bus.lu_rd_i;
      bus.rf_data_o = bus.lu_data_i;
    end
  end

  // A slot is live when its distance from the read pointer is below the count.
  always_comb begin
    w_slot_vld = '0;
    w_pend_hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      w_slot_vld[i] = ({1'b0, PTR_W'(PTR_W'(i) - r_rd_ptr)} < r_count);
      if (w_slot_vld[i] &&
          (((bus.chk_rs1_i != 5'd0) && (r_rd_mem[i] == bus.chk_rs1_i)) ||
           ((bus.chk_rs2_i != 5'd0) && (r_rd_mem[i] == bus.chk_rs2_i))))
        w_pend_hit = 1'b1;
    end
  end

  assign bus.lu_ready_o   = w_lu_ready;
  assign bus.pend_hit_o   = !rst && w_pend_hit;
  assign bus.stall_o      = !rst && !w_empty && (r_age >= AGE_W'(STARVE_LIMIT));
  assign bus.fifo_count_o = rst ? '0 : r_count;

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_age    <= '0;
    end else begin
      if (w_enq) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_deq) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      r_count <= w_count_next;
      r_age   <= w_age_next;
    end
  end

  // NOTE: storage is not reset; the count alone decides which slots hold valid data.
  always_ff @(posedge clk) begin
    if (w_enq) begin
      r_rd_mem[r_wr_ptr]   <= bus.lu_rd_i;
      r_data_mem[r_wr_ptr] <= bus.lu_data_i;
    end
  end
endmodule

// File: tb/tb_wb_port_arbiter.sv
// Scoreboard bench for wb_port_arbiter: a queue model of the LU FIFO predicts
// each cycle's write, handshake, stall, pending-hit and occupancy.
module tb_wb_port_arbiter;
  localparam int XLEN         = 32;
  localparam int DEPTH        = 2;
  localparam int STARVE_LIMIT = 4;

  typedef struct {
    logic [4:0]      rd;
    logic [XLEN-1:0] data;
  } wr_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  wb_port_arbiter_if #(.XLEN(XLEN), .DEPTH(DEPTH)) bus ();

  wb_port_arbiter #(
    .XLEN(XLEN), .DEPTH(DEPTH), .STARVE_LIMIT(STARVE_LIMIT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  wr_t m_q[$];
  wr_t sb_q[$];
  int  m_age    = 0;
  int  n_checks = 0;
  int  n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
  endtask

  task automatic drive(input logic pwe, input logic [4:0] prd, input logic [XLEN-1:0] pdat,
                       input logic lv, input logic [4:0] lrd, input logic [XLEN-1:0] ldat,
                       input logic [4:0] rs1, input logic [4:0] rs2);
    bus.pipe_we_i   = pwe;
    bus.pipe_rd_i   = prd;
    bus.pipe_data_i = pdat;
    bus.lu_valid_i  = lv;
    bus.lu_rd_i     = lrd;
    bus.lu_data_i   = ldat;
    bus.chk_rs1_i   = rs1;
    bus.chk_rs2_i   = rs2;
  endtask

  // One clock cycle: drive, predict, compare mid-cycle, then advance the model.
  task automatic step(input logic pwe, input logic [4:0] prd, input logic [XLEN-1:0] pdat,
                      input logic lv, input logic [4:0] lrd, input logic [XLEN-1:0] ldat,
                      input logic [4:0] rs1, input logic [4:0] rs2,
                      output logic o_ready, output logic o_stall);
    bit  deq, byp, exp_ready, exp_stall, exp_pend, was_busy;
    wr_t w;
    drive(pwe, prd, pdat, lv, lrd, ldat, rs1, rs2);
    @(negedge clk);
    deq = 0;
    byp = 0;
    if (pwe && prd != 5'd0) begin
      w.rd = prd; w.data = pdat; sb_q.push_back(w);
    end else if (m_q.size() > 0) begin
      sb_q.push_back(m_q[0]); deq = 1;
    end else if (lv && lrd != 5'd0) begin
      w.rd = lrd; w.data = ldat; sb_q.push_back(w); byp = 1;
    end
    exp_ready = (m_q.size() < DEPTH) || deq;
    exp_stall = (m_q.size() > 0) && (m_age >= STARVE_LIMIT);
    exp_pend  = 0;
    foreach (m_q[k])
      if ((rs1 != 5'd0 && m_q[k].rd == rs1) || (rs2 != 5'd0 && m_q[k].rd == rs2)) exp_pend = 1;
    check("lu_ready", bus.lu_ready_o, exp_ready);
    check("stall", bus.stall_o, exp_stall);
    check("pend_hit", bus.pend_hit_o, exp_pend);
    check("fifo_count", bus.fifo_count_o, m_q.size());
    check("rf_we", bus.rf_we_o, sb_q.size() > 0);
    if (sb_q.size() > 0) begin
      w = sb_q.pop_front();
      if (bus.rf_we_o) begin
        check("rf_addr", bus.rf_addr_o, w.rd);
        check("rf_data", bus.rf_data_o, w.data);
      end
    end
    o_ready = bus.lu_ready_o;
    o_stall = bus.stall_o;
    @(posedge clk);
    was_busy = m_q.size() > 0;
    if (deq) void'(m_q.pop_front());
    if (lv && exp_ready && lrd != 5'd0 && !byp) begin
      w.rd = lrd; w.data = ldat; m_q.push_back(w);
    end
    if (deq || !was_busy) m_age = 0;
    else if (m_age < STARVE_LIMIT) m_age++;
    #1;
  endtask

  task automatic do_reset(input logic [4:0] rs1);
    rst = 1'b1;
    drive(1'b0, 5'd0, '0, 1'b0, 5'd0, '0, rs1, 5'd0);
    @(negedge clk);
    check("rst_we", bus.rf_we_o, 1'b0);
    check("rst_ready", bus.lu_ready_o, 1'b0);
    check("rst_stall", bus.stall_o, 1'b0);
    check("rst_pend", bus.pend_hit_o, 1'b0);
    check("rst_count", bus.fifo_count_o, 0);
    check("rst_addr", bus.rf_addr_o, 5'd0);
    check("rst_data", bus.rf_data_o, '0);
    @(posedge clk);
    m_q.delete();
    sb_q.delete();
    m_age = 0;
    #1;
    rst = 1'b0;
    #1;
    check("post_rst_count", bus.fifo_count_o, 0);
    check("post_rst_we", bus.rf_we_o, 1'b0);
    check("post_rst_stall", bus.stall_o, 1'b0);
  endtask

  initial begin
    logic            rdy, stl;
    wr_t             lu_list[$];
    wr_t             w;
    int              waits, guard;
    logic            hold_v, stall_prev, pwe;
    logic [4:0]      hold_rd, prd;
    logic [XLEN-1:0] hold_data;

    drive(1'b0, 5'd0, '0, 1'b0, 5'd0, '0, 5'd0, 5'd0);
    do_reset(5'd0);

    // Bypass into an empty FIFO with an idle pipe.
    step(0, 5'd0, '0, 1, 5'd5, 32'hDEADBEEF, 5'd0, 5'd0, rdy, stl);
    check("bypass_count", bus.fifo_count_o, 0);

    // Pipe priority, LU buffered, drained on next idle pipe cycle.
    step(1, 5'd3, 32'h11, 1, 5'd7, 32'h22, 5'd0, 5'd0, rdy, stl);
    check("buffered_count", bus.fifo_count_o, 1);
    step(0, 5'd0, '0, 0, 5'd0, '0, 5'd0, 5'd0, rdy, stl);
    check("drained_count", bus.fifo_count_o, 0);

    // Back-pressure: busy pipe, three LU results, the third must wait.
    lu_list = '{'{5'd10, 32'hA1}, '{5'd11, 32'hA2}, '{5'd12, 32'hA3}};
    for (int c = 0; c < 4; c++) begin
      w = lu_list[0];
      step(1, 5'(c + 1), 32'(c), lu_list.size() > 0, w.rd, w.data, 5'd0, 5'd0, rdy, stl);
      if (c == 2) check("bp_hold", rdy, 1'b0);
      if (rdy && lu_list.size() > 0) void'(lu_list.pop_front());
      check("bp_count_max", bus.fifo_count_o <= 2, 1'b1);
    end
    w = lu_list[0];
    step(1, 5'd0, 32'h5, 1, w.rd, w.data, 5'd0, 5'd0, rdy, stl);
    check("x0_frees_port", rdy, 1'b1);
    if (rdy) void'(lu_list.pop_front());
    guard = 0;
    while ((m_q.size() > 0 || lu_list.size() > 0) && guard < 10) begin
      w = lu_list.size() > 0 ? lu_list[0] : '{5'd0, '0};
      step(0, 5'd0, '0, lu_list.size() > 0, w.rd, w.data, 5'd0, 5'd0, rdy, stl);
      if (rdy && lu_list.size() > 0) void'(lu_list.pop_front());
      guard++;
    end
    check("bp_drain_timeout", guard < 10, 1'b1);

    // Starvation: one buffered entry behind a continuously writing pipe.
    step(1, 5'd2, 32'h1, 1, 5'd20, 32'hBB, 5'd0, 5'd0, rdy, stl);
    waits = 0;
    for (int c = 0; c < 10; c++) begin
      step(1, 5'd2, 32'(c), 0, 5'd0, '0, 5'd0, 5'd0, rdy, stl);
      if (stl) break;
      waits++;
    end
    check("starve_wait", waits, STARVE_LIMIT);
    step(0, 5'd0, '0, 0, 5'd0, '0, 5'd0, 5'd0, rdy, stl);
    step(1, 5'd2, 32'h9, 0, 5'd0, '0, 5'd0, 5'd0, rdy, stl);
    check("starve_release", stl, 1'b0);

    // Pending-register query.
    step(1, 5'd2, 32'h1, 1, 5'd9, 32'h99, 5'd0, 5'd0, rdy, stl);
    step(1, 5'd2, 32'h2, 0, 5'd0, '0, 5'd9, 5'd0, rdy, stl);
    check("pend_rs1", bus.pend_hit_o, 1'b1);
    drive(1, 5'd2, 32'h3, 0, 5'd0, '0, 5'd0, 5'd9);
    #1;
    check("pend_rs2", bus.pend_hit_o, 1'b1);
    step(1, 5'd2, 32'h3, 0, 5'd0, '0, 5'd0, 5'd9, rdy, stl);
    step(0, 5'd0, '0, 0, 5'd0, '0, 5'd9, 5'd0, rdy, stl);
    step(0, 5'd0, '0, 0, 5'd0, '0, 5'd9, 5'd0, rdy, stl);
    check("pend_clear_rs1", bus.pend_hit_o, 1'b0);
    step(0, 5'd0, '0, 0, 5'd0, '0, 5'd0, 5'd9, rdy, stl);

    // Reset mid-drain: two buffered entries must vanish without a write.
    step(1, 5'd2, 32'h1, 1, 5'd12, 32'hC1, 5'd0, 5'd0, rdy, stl);
    step(1, 5'd2, 32'h2, 1, 5'd13, 32'hC2, 5'd0, 5'd0, rdy, stl);
    check("prereset_count", bus.fifo_count_o, 2);
    do_reset(5'd12);
    step(0, 5'd0, '0, 0, 5'd0, '0, 5'd12, 5'd13, rdy, stl);
    step(0, 5'd0, '0, 0, 5'd0, '0, 5'd12, 5'd13, rdy, stl);

    // Random traffic honouring the stall contract and the LU hold rule.
    hold_v = 0; hold_rd = '0; hold_data = '0; stall_prev = 0;
    for (int c = 0; c < 300; c++) begin
      if (!hold_v && $urandom_range(0, 1) == 1) begin
        hold_v    = 1;
        hold_rd   = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
        hold_data = $urandom;
      end
      pwe = stall_prev ? 1'b0 : ($urandom_range(0, 3) != 0);
      prd = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      step(pwe, prd, $urandom, hold_v, hold_rd, hold_data,
           5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), rdy, stl);
      if (rdy) hold_v = 0;
      stall_prev = stl;
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
